dl_controller: RTL and testbench

- Data-load controller between four processing cores and one shared 64-bit-wide data memory.
- Each memory line packs four 16-bit elements. A core addresses an element as (line << 2) + lane.
- The controller merges concurrent core reads to the same line into one memory read and returns each core its 16-bit lane.
- Reads to different lines are serialised by fixed priority.

---
 rtl/dl_if.sv | 27 ++
 rtl/dl_controller.sv | 94 +++++++++
 tb/tb_dl_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dl_if.sv
// Core/memory signal bundle for the data-load controller.
// The master side drives requests and memory data; the controller is the slave.
interface dl_if;
    logic [63:0] data;
    logic        mr1, mr2, mr3, mr4;
    logic [15:0] maddr1, maddr2, maddr3, maddr4;
    logic        memread;
    logic [15:0] memaddr;
    logic [15:0] dout1, dout2, dout3, dout4;
    logic        dv1, dv2, dv3, dv4;

    modport master (
        output data, mr1, mr2, mr3, mr4,
        output maddr1, maddr2, maddr3, maddr4,
        input  memread, memaddr,
        input  dout1, dout2, dout3, dout4,
        input  dv1, dv2, dv3, dv4
    );

    modport slave (
        input  data, mr1, mr2, mr3, mr4,
        input  maddr1, maddr2, maddr3, maddr4,
        output memread, memaddr,
        output dout1, dout2, dout3, dout4,
        output dv1, dv2, dv3, dv4
    );
endinterface

// File: rtl/dl_controller.sv
// Four-core data-load controller: merges same-line reads into one memory
// access, serialises distinct lines by fixed priority (core 1 first).
module dl_controller #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic CLK,
    input  logic RSTN,
    dl_if.slave  bus
);

    logic [3:0]        mr;
    logic [ADDR_W-1:0] maddr [4];
    logic [WORD_W-1:0] dout  [4];
    logic [ADDR_W-1:0] sa    [4];
    logic [3:0]        dv;
    logic [3:0]        pending;
    logic [3:0]        served;
    logic [ADDR_W-3:0] lead;

    assign mr       = {bus.mr4, bus.mr3, bus.mr2, bus.mr1};
    assign maddr[0] = bus.maddr1;
    assign maddr[1] = bus.maddr2;
    assign maddr[2] = bus.maddr3;
    assign maddr[3] = bus.maddr4;

    function automatic logic [WORD_W-1:0] lane_sel(
        input logic [63:0] d,
        input logic [1:0]  sel
    );
        logic [WORD_W-1:0] r;
        unique case (sel)
            2'd0: r = d[63:48];
            2'd1: r = d[47:32];
            2'd2: r = d[31:16];
            2'd3: r = d[15:0];
        endcase
        return r;
    endfunction

    // A held request stays served until its address moves away from SA
    always_comb begin
        pending = '0;
        for (int i = 0; i < 4; i++)
            pending[i] = mr[i] & (~dv[i] | (maddr[i] != sa[i]));
    end

    // Descending scan so the lowest-numbered pending core wins
    always_comb begin
        lead = '0;
        for (int i = 3; i >= 0; i--)
            if (pending[i])
                lead = maddr[i][ADDR_W-1:2];
    end

    always_comb begin
        served = '0;
        for (int i = 0; i < 4; i++)
            served[i] = pending[i] & (maddr[i][ADDR_W-1:2] == lead);
    end

    assign bus.memread = |pending;
    assign bus.memaddr = {2'b00, lead};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < 4; i++) begin
                dout[i] <= '0;
                sa[i]   <= '0;
            end
            dv <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (served[i]) begin
                    dout[i] <= lane_sel(bus.data, maddr[i][1:0]);
                    sa[i]   <= maddr[i];
                    dv[i]   <= 1'b1;
                end else if (!mr[i]) begin
                    dv[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.dout1 = dout[0];
    assign bus.dout2 = dout[1];
    assign bus.dout3 = dout[2];
    assign bus.dout4 = dout[3];
    assign bus.dv1   = dv[0];
    assign bus.dv2   = dv[1];
    assign bus.dv3   = dv[2];
    assign bus.dv4   = dv[3];

endmodule

// File: tb/tb_dl_controller.sv
// Scoreboard bench for dl_controller: expectations are queued with the
// stimulus and compared when the combinational or registered outputs settle.
module tb_dl_controller;

    logic clk;
    logic rstn;
    dl_if bus ();

    dl_controller dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus.slave)
    );

    logic [63:0] mem [0:255];
    assign bus.data = mem[bus.memaddr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t cq[$];
    exp_t rq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [15:0] exp_dout [4];

    localparam int S_RD = 0;
    localparam int S_MA = 1;
    localparam int S_DO = 2;
    localparam int S_DV = 6;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            0: return {31'd0, bus.memread};
            1: return {16'd0, bus.memaddr};
            2: return {16'd0, bus.dout1};
            3: return {16'd0, bus.dout2};
            4: return {16'd0, bus.dout3};
            5: return {16'd0, bus.dout4};
            6: return {31'd0, bus.dv1};
            7: return {31'd0, bus.dv2};
            8: return {31'd0, bus.dv3};
            9: return {31'd0, bus.dv4};
            default: return 32'hdead;
        endcase
    endfunction

    task automatic push(input bit regd, input string tag, input int sig,
                        input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        if (regd) rq.push_back(e);
        else      cq.push_back(e);
    endtask

    task automatic drain(input bit regd);
        exp_t e;
        if (regd) begin
            while (rq.size() > 0) begin
                e = rq.pop_front();
                chk(e.tag, obs(e.sig), e.exp);
            end
        end else begin
            while (cq.size() > 0) begin
                e = cq.pop_front();
                chk(e.tag, obs(e.sig), e.exp);
            end
        end
    endtask

    function automatic logic [15:0] elem(input logic [63:0] d,
                                         input logic [1:0] l);
        logic [63:0] t;
        t = d >> (16 * (3 - int'(l)));
        return t[15:0];
    endfunction

    task automatic drive(input logic [3:0] mr, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3,
                         input logic [15:0] a4);
        {bus.mr4, bus.mr3, bus.mr2, bus.mr1} = mr;
        bus.maddr1 = a1;
        bus.maddr2 = a2;
        bus.maddr3 = a3;
        bus.maddr4 = a4;
    endtask

    task automatic settle_and_step();
        #1 drain(1'b0);
        @(posedge clk);
        #1 drain(1'b1);
    endtask

    // All four cores on one line: one read, every core gets its lane
    task automatic line_case(input string tag, input logic [13:0] line,
                             input logic [63:0] d, input logic [1:0] l1,
                             input logic [1:0] l2, input logic [1:0] l3,
                             input logic [1:0] l4);
        logic [15:0] a [4];
        logic [1:0]  ln [4];
        ln[0] = l1; ln[1] = l2; ln[2] = l3; ln[3] = l4;
        mem[line[7:0]] = d;
        for (int i = 0; i < 4; i++)
            a[i] = {line, ln[i]};
        drive(4'hf, a[0], a[1], a[2], a[3]);
        push(0, {tag, "_rd"}, S_RD, 1);
        push(0, {tag, "_ma"}, S_MA, {18'd0, line});
        for (int i = 0; i < 4; i++) begin
            exp_dout[i] = elem(d, ln[i]);
            push(1, $sformatf("%s_do%0d", tag, i + 1), S_DO + i,
                 {16'd0, exp_dout[i]});
            push(1, $sformatf("%s_dv%0d", tag, i + 1), S_DV + i, 1);
        end
        push(1, {tag, "_idle"}, S_RD, 0);
        settle_and_step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rstn = 1'b0;
        drive(4'h0, 0, 0, 0, 0);
        #1;
        push(0, "rst_rd", S_RD, 0);
        push(0, "rst_ma", S_MA, 0);
        for (int i = 0; i < 4; i++) begin
            push(0, $sformatf("rst_do%0d", i + 1), S_DO + i, 0);
            push(0, $sformatf("rst_dv%0d", i + 1), S_DV + i, 0);
        end
        drain(1'b0);
        #10 rstn = 1'b1;
        @(posedge clk);
        #1;

        line_case("shared", 14'd0, {16'd1, 16'd5, 16'd9, 16'd13},
                  2'd0, 2'd0, 2'd1, 2'd1);
        line_case("newline", 14'd1, {16'd1, 16'd2, 16'd3, 16'd4},
                  2'd0, 2'd1, 2'd0, 2'd1);

        for (int l = 2; l <= 7; l++) begin
            logic [63:0] d;
            logic [15:0] b;
            b = 16'(l * 16);
            d = {b + 16'd1, b + 16'd2, b + 16'd3, b + 16'd4};
            if (l == 6) d = {16'd4, 16'd8, 16'd12, 16'd16};
            if (l == 7) d = {16'd13, 16'd14, 16'd15, 16'd16};
            if (l % 2 == 0)
                line_case($sformatf("sweep%0d", l), 14'(l), d,
                          2'd0, 2'd0, 2'd1, 2'd1);
            else
                line_case($sformatf("sweep%0d", l), 14'(l), d,
                          2'd0, 2'd1, 2'd0, 2'd1);
        end

        // Three distinct lines contend; old DV stays up until re-served
        mem[0] = {16'h0a00, 16'h0a01, 16'h0a02, 16'h0a03};
        mem[1] = {16'h0b00, 16'h0b01, 16'h0b02, 16'h0b03};
        mem[2] = {16'h0c00, 16'h0c01, 16'h0c02, 16'h0c03};
        drive(4'hf, 16'd0, 16'd4, 16'd1, 16'd8);
        push(0, "cf0_rd", S_RD, 1);
        push(0, "cf0_ma", S_MA, 0);
        push(1, "cf0_do1", S_DO + 0, 16'h0a00);
        push(1, "cf0_do3", S_DO + 2, 16'h0a01);
        push(1, "cf0_do2", S_DO + 1, {16'd0, exp_dout[1]});
        push(1, "cf0_do4", S_DO + 3, {16'd0, exp_dout[3]});
        push(1, "cf0_dv2", S_DV + 1, 1);
        settle_and_step();
        push(0, "cf1_rd", S_RD, 1);
        push(0, "cf1_ma", S_MA, 1);
        push(1, "cf1_do2", S_DO + 1, 16'h0b00);
        push(1, "cf1_do4", S_DO + 3, {16'd0, exp_dout[3]});
        settle_and_step();
        push(0, "cf2_rd", S_RD, 1);
        push(0, "cf2_ma", S_MA, 2);
        push(1, "cf2_do4", S_DO + 3, 16'h0c00);
        push(1, "cf2_rd_after", S_RD, 0);
        push(1, "cf2_ma_after", S_MA, 0);
        settle_and_step();

        // Lane 3 on core 1 alone, then release the request
        mem[0] = {16'h1111, 16'h2222, 16'h3333, 16'hbeef};
        drive(4'b0001, 16'd3, 16'd4, 16'd1, 16'd8);
        push(0, "l3_rd", S_RD, 1);
        push(0, "l3_ma", S_MA, 0);
        push(1, "l3_do1", S_DO + 0, 16'hbeef);
        push(1, "l3_dv1", S_DV + 0, 1);
        push(1, "l3_dv2", S_DV + 1, 0);
        push(1, "l3_dv4", S_DV + 3, 0);
        settle_and_step();
        drive(4'b0000, 16'd3, 16'd4, 16'd1, 16'd8);
        push(0, "idle_rd", S_RD, 0);
        push(0, "idle_ma", S_MA, 0);
        push(1, "idle_dv1", S_DV + 0, 0);
        push(1, "idle_do1", S_DO + 0, 16'hbeef);
        settle_and_step();

        // Serve everyone, then pull reset between edges
        line_case("pre_rst", 14'd0, mem[0], 2'd0, 2'd1, 2'd2, 2'd3);
        drive(4'hf, 16'd0, 16'd1, 16'd2, 16'd3);
        #1 rstn = 1'b0;
        push(0, "arst_rd", S_RD, 1);
        push(0, "arst_ma", S_MA, 0);
        for (int i = 0; i < 4; i++) begin
            push(0, $sformatf("arst_do%0d", i + 1), S_DO + i, 0);
            push(0, $sformatf("arst_dv%0d", i + 1), S_DV + i, 0);
        end
        #1 drain(1'b0);
        #1 rstn = 1'b1;
        push(1, "post_do1", S_DO + 0, 16'h1111);
        push(1, "post_do4", S_DO + 3, 16'hbeef);
        push(1, "post_dv3", S_DV + 2, 1);
        push(1, "post_idle", S_RD, 0);
        settle_and_step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
